// File: rtl/gpio_intr_ctrl.sv
// GPIO input-interrupt controller: pad synchroniser, per-pin debounce, edge/level
// event detection, sticky status with software clear/set and one masked interrupt line.
module gpio_intr_ctrl #(
    parameter int NPIN     = 32,
    parameter int SYNC_STG = 2,
    parameter int DB_W     = 8
) (
    input  logic            mclk,
    input  logic            h_reset,
    input  logic [NPIN-1:0] pad_gpio_in,
    input  logic [NPIN-1:0] cfg_gpio_dir_sel,
    input  logic [NPIN-1:0] cfg_gpio_posedge_int_sel,
    input  logic [NPIN-1:0] cfg_gpio_negedge_int_sel,
    input  logic [NPIN-1:0] cfg_gpio_level_sel,
    input  logic [NPIN-1:0] cfg_gpio_int_mask,
    input  logic [NPIN-1:0] cfg_gpio_db_en,
    input  logic [DB_W-1:0] cfg_gpio_db_limit,
    input  logic [NPIN-1:0] cfg_gpio_int_clr,
    input  logic [NPIN-1:0] cfg_gpio_int_set,
    output logic [NPIN-1:0] gpio_data_in,
    output logic [NPIN-1:0] gpio_int_stat,
    output logic            gpio_intr
);

    localparam int ARM_W = $clog2(SYNC_STG + 2);

    logic [NPIN-1:0]  sync_q [SYNC_STG];
    logic [NPIN-1:0]  sync_w;
    logic [NPIN-1:0]  filt_q, filt_d;
    logic [NPIN-1:0]  prev_q;
    logic [DB_W-1:0]  cnt_q [NPIN];
    logic [DB_W-1:0]  cnt_d [NPIN];
    logic [ARM_W-1:0] arm_cnt_q;
    logic             arm_q;
    logic [NPIN-1:0]  ev_edge_w, ev_lvl_w, ev_w;
    logic [NPIN-1:0]  stat_q, stat_d;
    logic             intr_q, intr_d;

    assign sync_w = sync_q[SYNC_STG-1];

    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            for (int s = 0; s < SYNC_STG; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= pad_gpio_in;
            for (int s = 1; s < SYNC_STG; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // A pin's filtered value moves only after limit+1 consecutive mismatching cycles;
    // ">=" keeps a count that overshot a lowered limit from stalling.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NPIN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!cfg_gpio_db_en[i]) begin
                filt_d[i] = sync_w[i];
                cnt_d[i]  = '0;
            end else if (sync_w[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= cfg_gpio_db_limit) begin
                filt_d[i] = sync_w[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            filt_q <= '0;
            prev_q <= '0;
            for (int i = 0; i < NPIN; i++) cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            prev_q <= filt_q;
            for (int i = 0; i < NPIN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Hold off events until the synchroniser, filter and prev stages all carry pad data.
    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            arm_cnt_q <= ARM_W'(SYNC_STG + 1);
            arm_q     <= 1'b0;
        end else if (!arm_q) begin
            if (arm_cnt_q == '0) arm_q <= 1'b1;
            else                 arm_cnt_q <= arm_cnt_q - ARM_W'(1);
        end
    end

    assign ev_edge_w = (cfg_gpio_posedge_int_sel & ~prev_q &  filt_q)
                     | (cfg_gpio_negedge_int_sel &  prev_q & ~filt_q);
    assign ev_lvl_w  = (cfg_gpio_posedge_int_sel &  filt_q)
                     | (cfg_gpio_negedge_int_sel & ~filt_q);
    assign ev_w      = ((cfg_gpio_level_sel & ev_lvl_w) | (~cfg_gpio_level_sel & ev_edge_w))
                     & ~cfg_gpio_dir_sel & {NPIN{arm_q}};

    assign stat_d = (stat_q & ~cfg_gpio_int_clr) | ev_w | cfg_gpio_int_set;
    assign intr_d = |(stat_q & cfg_gpio_int_mask);

    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            stat_q <= '0;
            intr_q <= 1'b0;
        end else begin
            stat_q <= stat_d;
            intr_q <= intr_d;
        end
    end

    assign gpio_data_in  = filt_q;
    assign gpio_int_stat = stat_q;
    assign gpio_intr     = intr_q;

endmodule
